// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter, plus a debug view of the FSM state.
interface uart_tx_if #(
    parameter int DATA_W = 8
);
    // Handshake: a byte moves when tx_valid && tx_ready are both high on a clk edge.
    // The producer holds tx_valid and tx_data stable until that edge. tx_ready never
    // depends on tx_valid.
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic [2:0]        state_dbg;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  state_dbg
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output state_dbg
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_W data bits LSB first, even parity, stop; one holding register.
// Define UART_TX_TWO_STOP_EN to stretch the stop bit to two baud intervals.
module uart_tx #(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic [CNT_W-1:0]  cnt;
    logic              stop_last;
    logic              load;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt;
    assign stop_last = (state == STOP) && stop_cnt;
`else
    assign stop_last = (state == STOP);
`endif

    // A new frame starts from IDLE or straight out of the final stop interval.
    assign load = baud_tick && hold_full && ((state == IDLE) || stop_last);

    assign bus.tx_ready  = !hold_full;
    assign bus.state_dbg = state;
    assign busy          = (state != IDLE) || hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            cnt       <= '0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt  <= 1'b0;
`endif
        end else begin
            tx_done <= baud_tick && stop_last;

            if (bus.tx_valid && !hold_full) begin
                hold_q    <= bus.tx_data;
                hold_full <= 1'b1;
            end

            if (load) begin
                shift_q   <= hold_q;
                parity_q  <= ^hold_q;
                hold_full <= 1'b0;
                tx        <= 1'b0;
                state     <= START;
            end else if (baud_tick) begin
                case (state)
                    IDLE: tx <= 1'b1;
                    START: begin
                        tx    <= shift_q[0];
                        cnt   <= '0;
                        state <= DATA;
                    end
                    DATA: begin
                        if (cnt == LAST_BIT) begin
                            tx    <= parity_q;
                            state <= PARITY;
                        end else begin
                            // Shift so the next data bit is always at index 1.
                            cnt     <= cnt + 1'b1;
                            tx      <= shift_q[1];
                            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                        end
                    end
                    PARITY: begin
                        tx    <= 1'b1;
                        state <= STOP;
`ifdef UART_TX_TWO_STOP_EN
                        stop_cnt <= 1'b0;
`endif
                    end
                    STOP: begin
                        tx <= 1'b1;
                        if (stop_last) begin
                            state <= IDLE;
                        end
`ifdef UART_TX_TWO_STOP_EN
                        stop_cnt <= 1'b1;
`endif
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
